// File: rtl/fft_twiddle_feeder_pkg.sv
// fft_twiddle_feeder_pkg: shared widths, twiddle scale and the round/saturate rule
package fft_twiddle_feeder_pkg;
  localparam int DATA_W = 32;
  localparam int TWID_W = 18;
  localparam logic signed [17:0] TW_ONE = 18'sd65536;
  localparam real PI = 3.14159265358979323846;
  function automatic int tw_quant(input real v, input int w);
    int r, hi, lo;
    r = v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    return r > hi ? hi : r < lo ? lo : r;
  endfunction
endpackage

// File: rtl/fft_twiddle_feeder_if.sv
// fft_twiddle_feeder_if: sample stream in, multiplier operands and status out
interface fft_twiddle_feeder_if import fft_twiddle_feeder_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int TW = TWID_W
);
  logic in_valid, in_sop;
  logic signed [DW-1:0] in_re, in_im, a, b;
  logic signed [TW-1:0] c, d;
  logic out_valid, out_sop, mult_valid, mult_sop, frame_done, sop_err;
  modport master (
    output in_valid, in_sop, in_re, in_im,
    input  a, b, c, d, out_valid, out_sop, mult_valid, mult_sop, frame_done, sop_err
  );
  modport slave (
    input  in_valid, in_sop, in_re, in_im,
    output a, b, c, d, out_valid, out_sop, mult_valid, mult_sop, frame_done, sop_err
  );
endinterface

// File: rtl/fft_twiddle_feeder_rom.sv
// fft_twiddle_feeder_rom: N/2-entry {cos, -sin} twiddle table with a registered, enabled read
// Table contents are elaborated from the quantisation rule so no external hex image is needed.
module fft_twiddle_feeder_rom import fft_twiddle_feeder_pkg::*; #(
  parameter int N_LOG2 = 10,
  parameter int TW = TWID_W,
  localparam int KW = N_LOG2 - 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en_i,
  input  logic [KW-1:0]        k_i,
  output logic signed [TW-1:0] cos_o,
  output logic signed [TW-1:0] nsin_o
);
  logic signed [TW-1:0] cos_rom [1<<KW];
  logic signed [TW-1:0] nsin_rom [1<<KW];
  logic signed [TW-1:0] cos_q, nsin_q;
  for (genvar i = 0; i < (1 << KW); i++) begin : g_rom
    localparam real ANG = 2.0 * PI * i / (2.0 ** N_LOG2);
    assign cos_rom[i] = TW'(tw_quant(real'(TW_ONE) * $cos(ANG), TW));
    assign nsin_rom[i] = TW'(tw_quant(-real'(TW_ONE) * $sin(ANG), TW));
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cos_q  <= '0;
      nsin_q <= '0;
    end else if (en_i) begin
      cos_q  <= cos_rom[k_i];
      nsin_q <= nsin_rom[k_i];
    end
  end
  assign cos_o  = cos_q;
  assign nsin_o = nsin_q;
endmodule

// File: rtl/fft_twiddle_feeder.sv
// fft_twiddle_feeder: counts samples per frame, derives the SDF stage twiddle and aligns it with data
// Operands appear 2 cycles after input; mult_valid/mult_sop trail them by MULT_LAT+3 cycles.
module fft_twiddle_feeder import fft_twiddle_feeder_pkg::*; #(
  parameter int N_LOG2   = 10,
  parameter int STAGE    = 0,
  parameter int DW       = DATA_W,
  parameter int TW       = TWID_W,
  parameter int MULT_LAT = 3
) (
  input logic clk,
  input logic rstn,
  fft_twiddle_feeder_if.slave bus
);
  localparam int N  = 1 << N_LOG2;
  localparam int KW = N_LOG2 - 1;
  localparam int B  = N >> STAGE;
  localparam int H  = B / 2;
  localparam int ML = MULT_LAT + 3;
  logic [N_LOG2-1:0] n_q, n_d, n_cur, p, k_full;
  logic [KW-1:0] k_q, k_d;
  logic signed [DW-1:0] re_q, im_q, a_q, b_q;
  logic v1_q, s1_q, v2_q, s2_q, err_q, err_d;
  logic [ML-1:0] mv_q, ms_q;
  // A sop forces the current sample to index 0 regardless of the count.
  always_comb begin
    n_cur  = (bus.in_valid && bus.in_sop) ? '0 : n_q;
    p      = n_cur & N_LOG2'(B - 1);
    k_full = (p < N_LOG2'(H)) ? '0 : (p - N_LOG2'(H)) << STAGE;
    k_d    = k_full[KW-1:0];
    n_d    = bus.in_valid ? n_cur + N_LOG2'(1) : n_q;
    err_d  = err_q | (bus.in_valid & bus.in_sop & (n_q != '0));
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      n_q   <= '0;
      err_q <= 1'b0;
      k_q   <= '0;
      re_q  <= '0;
      im_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      v1_q  <= 1'b0;
      s1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s2_q  <= 1'b0;
      mv_q  <= '0;
      ms_q  <= '0;
    end else begin
      n_q   <= n_d;
      err_q <= err_d;
      v1_q  <= bus.in_valid;
      s1_q  <= bus.in_valid & bus.in_sop;
      if (bus.in_valid) begin
        k_q  <= k_d;
        re_q <= bus.in_re;
        im_q <= bus.in_im;
      end
      v2_q <= v1_q;
      s2_q <= s1_q;
      if (v1_q) begin
        a_q <= re_q;
        b_q <= im_q;
      end
      mv_q <= {mv_q[ML-2:0], v2_q};
      ms_q <= {ms_q[ML-2:0], s2_q};
    end
  end
  fft_twiddle_feeder_rom #(.N_LOG2(N_LOG2), .TW(TW)) u_rom (
    .clk    (clk),
    .rstn   (rstn),
    .en_i   (v1_q),
    .k_i    (k_q),
    .cos_o  (bus.c),
    .nsin_o (bus.d)
  );
  assign bus.a          = a_q;
  assign bus.b          = b_q;
  assign bus.out_valid  = v2_q;
  assign bus.out_sop    = s2_q;
  assign bus.mult_valid = mv_q[ML-1];
  assign bus.mult_sop   = ms_q[ML-1];
  assign bus.sop_err    = err_q;
  assign bus.frame_done = rstn & bus.in_valid & (&n_cur);
endmodule

// File: tb/tb_fft_twiddle_feeder.sv
// tb_fft_twiddle_feeder: random-stimulus bench for stage 0 and stage 1 feeders (N=16)
module tb_fft_twiddle_feeder;
  import fft_twiddle_feeder_pkg::*;
  localparam int NL = 4;
  localparam int N  = 16;
  localparam int ML = 3;
  localparam real PI_R = 3.14159265358979323846;
  typedef struct {
    int cyc;
    logic sop;
    int n;
    logic [DATA_W-1:0] re, im;
    int c0, d0, c1, d1;
  } out_t;
  typedef struct {
    int cyc;
    logic sop;
  } mult_t;
  logic clk = 0;
  logic rstn = 0;
  int cyc = 0, checks = 0, failures = 0, fd_count = 0;
  out_t oq[$];
  mult_t mq[$];
  int mn = 0;
  logic merr = 0;
  logic [DATA_W-1:0] ha = 0, hb = 0;
  int hc0 = 0, hd0 = 0, hc1 = 0, hd1 = 0;
  int obs_c0[N], obs_d0[N], obs_c1[N], obs_d1[N];

  fft_twiddle_feeder_if #(.DW(DATA_W), .TW(TWID_W)) bus0 ();
  fft_twiddle_feeder_if #(.DW(DATA_W), .TW(TWID_W)) bus1 ();
  fft_twiddle_feeder #(.N_LOG2(NL), .STAGE(0), .DW(DATA_W), .TW(TWID_W), .MULT_LAT(ML)) dut0 (
    .clk(clk), .rstn(rstn), .bus(bus0));
  fft_twiddle_feeder #(.N_LOG2(NL), .STAGE(1), .DW(DATA_W), .TW(TWID_W), .MULT_LAT(ML)) dut1 (
    .clk(clk), .rstn(rstn), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rnd(input real v);
    return v >= 0.0 ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  // Reference twiddle straight from the stage index rule: p = n mod B, upper half rotates.
  function automatic void twid(input int n, input int stage, output int c, output int d);
    int b, h, p, k;
    b = N >> stage;
    h = b / 2;
    p = n % b;
    k = p < h ? 0 : (p - h) * (1 << stage);
    c = rnd(65536.0 * $cos(2.0 * PI_R * k / N));
    d = rnd(-65536.0 * $sin(2.0 * PI_R * k / N));
  endfunction

  // One clock: score the outputs of the previous edge, then apply new inputs and update the model.
  task automatic step(input logic v, input logic s, input logic r_n);
    out_t e;
    mult_t m;
    logic ev, em, ems, fd_exp;
    int eff;
    @(negedge clk);
    ev = oq.size() > 0 && oq[0].cyc == cyc;
    checks++;
    if (bus0.out_valid !== ev || bus1.out_valid !== ev) begin
      failures++;
      $display("FAIL out_valid cyc=%0d got=%b/%b exp=%b", cyc, bus0.out_valid, bus1.out_valid, ev);
    end
    if (ev) begin
      e = oq.pop_front();
      ha = e.re; hb = e.im; hc0 = e.c0; hd0 = e.d0; hc1 = e.c1; hd1 = e.d1;
      obs_c0[e.n] = int'(bus0.c); obs_d0[e.n] = int'(bus0.d);
      obs_c1[e.n] = int'(bus1.c); obs_d1[e.n] = int'(bus1.d);
      checks++;
      if (bus0.out_sop !== e.sop || bus1.out_sop !== e.sop) begin
        failures++;
        $display("FAIL out_sop cyc=%0d got=%b/%b exp=%b", cyc, bus0.out_sop, bus1.out_sop, e.sop);
      end
    end
    checks++;
    if (bus0.a !== ha || bus0.b !== hb || bus1.a !== ha || bus1.b !== hb) begin
      failures++;
      $display("FAIL data cyc=%0d got a=%h b=%h exp a=%h b=%h", cyc, bus0.a, bus0.b, ha, hb);
    end
    checks++;
    if (int'(bus0.c) != hc0 || int'(bus0.d) != hd0 || int'(bus1.c) != hc1 || int'(bus1.d) != hd1) begin
      failures++;
      $display("FAIL twiddle cyc=%0d got s0=(%0d,%0d) s1=(%0d,%0d) exp s0=(%0d,%0d) s1=(%0d,%0d)",
               cyc, bus0.c, bus0.d, bus1.c, bus1.d, hc0, hd0, hc1, hd1);
    end
    em = mq.size() > 0 && mq[0].cyc == cyc;
    ems = em ? mq[0].sop : 1'b0;
    if (em) void'(mq.pop_front());
    checks++;
    if (bus0.mult_valid !== em || bus1.mult_valid !== em || bus0.mult_sop !== ems || bus1.mult_sop !== ems) begin
      failures++;
      $display("FAIL mult cyc=%0d got v=%b/%b s=%b/%b exp v=%b s=%b", cyc, bus0.mult_valid,
               bus1.mult_valid, bus0.mult_sop, bus1.mult_sop, em, ems);
    end
    checks++;
    if (bus0.sop_err !== merr || bus1.sop_err !== merr) begin
      failures++;
      $display("FAIL sop_err cyc=%0d got=%b/%b exp=%b", cyc, bus0.sop_err, bus1.sop_err, merr);
    end
    rstn = r_n;
    bus0.in_valid = v; bus0.in_sop = v & s;
    bus0.in_re = $urandom; bus0.in_im = $urandom;
    bus1.in_valid = bus0.in_valid; bus1.in_sop = bus0.in_sop;
    bus1.in_re = bus0.in_re; bus1.in_im = bus0.in_im;
    fd_exp = 1'b0;
    if (!r_n) begin
      oq.delete(); mq.delete();
      mn = 0; merr = 0;
      ha = 0; hb = 0; hc0 = 0; hd0 = 0; hc1 = 0; hd1 = 0;
    end else if (v) begin
      eff = s ? 0 : mn;
      if (s && mn != 0) merr = 1;
      fd_exp = (eff == N - 1);
      e.cyc = cyc + 2; e.sop = s; e.n = eff; e.re = bus0.in_re; e.im = bus0.in_im;
      twid(eff, 0, e.c0, e.d0);
      twid(eff, 1, e.c1, e.d1);
      oq.push_back(e);
      m.cyc = cyc + 2 + ML + 3; m.sop = s;
      mq.push_back(m);
      mn = (eff + 1) % N;
    end
    #1;
    checks++;
    if (bus0.frame_done !== fd_exp || bus1.frame_done !== fd_exp) begin
      failures++;
      $display("FAIL frame_done cyc=%0d got=%b/%b exp=%b", cyc, bus0.frame_done, bus1.frame_done, fd_exp);
    end
    if (bus0.frame_done === 1'b1) fd_count++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1);
  endtask

  task automatic send(input int len, input logic first_sop, input int max_gap);
    for (int i = 0; i < len; i++) begin
      repeat ($urandom_range(max_gap, 0)) step(1'b0, 1'b0, 1'b1);
      step(1'b1, first_sop && i == 0, 1'b1);
    end
  endtask

  task automatic test_reset;
    repeat (3) step(1'b0, 1'b0, 1'b0);
    checks++;
    if ({bus0.a, bus0.b, bus0.c, bus0.d, bus0.out_valid, bus0.out_sop, bus0.mult_valid, bus0.mult_sop,
         bus0.frame_done, bus0.sop_err} !== '0 ||
        {bus1.a, bus1.b, bus1.c, bus1.d, bus1.out_valid, bus1.out_sop, bus1.mult_valid, bus1.mult_sop,
         bus1.frame_done, bus1.sop_err} !== '0) begin
      failures++;
      $display("FAIL reset_state got a=%h c=%0d d=%0d ov=%b err=%b exp all zero", bus0.a, bus0.c, bus0.d,
               bus0.out_valid, bus0.sop_err);
    end
  endtask

  task automatic test_known_values;
    for (int i = 0; i < N; i++) begin
      obs_c0[i] = 999999; obs_d0[i] = 999999; obs_c1[i] = 999999; obs_d1[i] = 999999;
    end
    send(16, 1'b1, 0);
    idle(3);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs_c0[i] != 65536 || obs_d0[i] != 0) begin
        failures++;
        $display("FAIL s0_upper n=%0d got c=%0d d=%0d exp c=65536 d=0", i, obs_c0[i], obs_d0[i]);
      end
    end
    checks++;
    if (obs_c0[10] != 46341 || obs_d0[10] != -46341) begin
      failures++;
      $display("FAIL s0_n10 got c=%0d d=%0d exp c=46341 d=-46341", obs_c0[10], obs_d0[10]);
    end
    checks++;
    if (obs_c0[12] != 0 || obs_d0[12] != -65536) begin
      failures++;
      $display("FAIL s0_n12 got c=%0d d=%0d exp c=0 d=-65536", obs_c0[12], obs_d0[12]);
    end
    checks++;
    if (obs_c1[6] != 0 || obs_d1[6] != -65536) begin
      failures++;
      $display("FAIL s1_n6 got c=%0d d=%0d exp c=0 d=-65536", obs_c1[6], obs_d1[6]);
    end
    checks++;
    if (obs_c1[7] != -46341 || obs_d1[7] != -46341) begin
      failures++;
      $display("FAIL s1_n7 got c=%0d d=%0d exp c=-46341 d=-46341", obs_c1[7], obs_d1[7]);
    end
  endtask

  task automatic test_gaps;
    fd_count = 0;
    repeat (3) send(16, 1'b1, 3);
    idle(10);
    checks++;
    if (fd_count != 3) begin
      failures++;
      $display("FAIL gaps_frame_done got=%0d exp=3", fd_count);
    end
  endtask

  task automatic test_back_to_back;
    fd_count = 0;
    send(16, 1'b1, 0);
    send(16, 1'b1, 0);
    idle(10);
    checks++;
    if (fd_count != 2) begin
      failures++;
      $display("FAIL b2b_frame_done got=%0d exp=2", fd_count);
    end
  endtask

  task automatic test_early_sop;
    send(5, 1'b1, 0);
    send(16, 1'b1, 1);
    send(16, 1'b1, 0);
    idle(10);
    checks++;
    if (bus0.sop_err !== 1'b1 || bus1.sop_err !== 1'b1) begin
      failures++;
      $display("FAIL early_sop_sticky got=%b/%b exp=1", bus0.sop_err, bus1.sop_err);
    end
  endtask

  task automatic test_reset_mid;
    send(7, 1'b1, 0);
    step(1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ({bus0.a, bus0.b, bus0.c, bus0.d, bus0.out_valid, bus0.out_sop, bus0.mult_valid, bus0.mult_sop,
         bus0.frame_done, bus0.sop_err} !== '0 ||
        {bus1.a, bus1.b, bus1.c, bus1.d, bus1.out_valid, bus1.out_sop, bus1.mult_valid, bus1.mult_sop,
         bus1.frame_done, bus1.sop_err} !== '0) begin
      failures++;
      $display("FAIL mid_reset_zero got a=%h c=%0d ov=%b mv=%b err=%b exp all zero", bus0.a, bus0.c,
               bus0.out_valid, bus0.mult_valid, bus0.sop_err);
    end
    send(16, 1'b1, 2);
    idle(12);
    checks++;
    if (oq.size() != 0 || mq.size() != 0) begin
      failures++;
      $display("FAIL drain got pending out=%0d mult=%0d exp 0/0", oq.size(), mq.size());
    end
  endtask

  initial begin
    bus0.in_valid = 0; bus0.in_sop = 0; bus0.in_re = 0; bus0.in_im = 0;
    bus1.in_valid = 0; bus1.in_sop = 0; bus1.in_re = 0; bus1.in_im = 0;
    test_reset;
    test_known_values;
    test_gaps;
    test_back_to_back;
    test_early_sop;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
